// File: rtl/uart_receiver.sv
`default_nettype none
// uart_receiver: 8N1 serial receiver with mid-bit sampling, a ready/valid byte
// output, and one-cycle framing-error / overrun pulses.
module uart_receiver #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       framing_error,
  output logic       overrun,
  output logic       rx_busy
);
  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
  localparam int CW               = $clog2(SYMBOL_EDGE_TIME);
  localparam logic [CW-1:0] HALF_LAST = CW'(SAMPLE_TIME - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(SYMBOL_EDGE_TIME - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state, state_next;
  logic          sync1, rx;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          half_hit, full_hit, sample_now, shift_en, good_stop, bad_stop;

  assign rx_busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      rx    <= 1'b1;
    end else begin
      sync1 <= serial_in;
      rx    <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    half_hit   = (baud_cnt == HALF_LAST);
    full_hit   = (baud_cnt == FULL_LAST);
    sample_now = 1'b0;
    shift_en   = 1'b0;
    good_stop  = 1'b0;
    bad_stop   = 1'b0;
    case (state)
      IDLE: begin
        if (!rx) state_next = START;
      end
      START: begin
        // A start bit that is high again at mid-bit was only a glitch.
        if (half_hit) begin
          sample_now = 1'b1;
          state_next = rx ? IDLE : DATA;
        end
      end
      DATA: begin
        if (full_hit) begin
          sample_now = 1'b1;
          shift_en   = 1'b1;
          if (bit_cnt == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        if (full_hit) begin
          sample_now = 1'b1;
          good_stop  = rx;
          bad_stop   = !rx;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt  <= '0;
      bit_cnt   <= 3'd0;
      shift_reg <= 8'h00;
    end else begin
      if (sample_now || (state_next != state) || (state == IDLE)) baud_cnt <= '0;
      else                                                        baud_cnt <= baud_cnt + CW'(1);
      if (state != DATA)  bit_cnt <= 3'd0;
      else if (shift_en)  bit_cnt <= bit_cnt + 3'd1;
      if (shift_en) shift_reg[bit_cnt] <= rx;
    end
  end

  // A byte finishing on the handshake cycle replaces the consumed one without overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out       <= 8'h00;
      data_out_valid <= 1'b0;
      framing_error  <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      framing_error <= bad_stop;
      overrun       <= good_stop && data_out_valid && !data_out_ready;
      if (good_stop) begin
        data_out       <= shift_reg;
        data_out_valid <= 1'b1;
      end else if (data_out_valid && data_out_ready) begin
        data_out_valid <= 1'b0;
      end
    end
  end
endmodule
`default_nettype wire
